// File: rtl/rfft_pkg.sv
// rfft_pkg: shared types and constants for the rfft_4pt sequencer (rfft_ctrl).
package rfft_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STAGE,
        S_DRAIN,
        S_FIN
    } state_t;

    // Rotation added to the lower two bank read addresses, indexed by stage.
    localparam logic [4:0][2:0] OFF_TBL = {3'd4, 3'd7, 3'd6, 3'd4, 3'd0};

    // First-row mux select bundle, packed as {m11, m12, m13, m14}.
    typedef struct packed {
        logic       m11;
        logic [1:0] m12;
        logic [1:0] m13;
        logic       m14;
    } row1_t;

    localparam row1_t ROW1_A = '{m11: 1'b0, m12: 2'd1, m13: 2'd1, m14: 1'b1};
    localparam row1_t ROW1_B = '{m11: 1'b1, m12: 2'd0, m13: 2'd2, m14: 1'b0};
    localparam row1_t ROW1_C = '{m11: 1'b1, m12: 2'd0, m13: 2'd2, m14: 1'b1};
    localparam row1_t ROW1_D = '{m11: 1'b0, m12: 2'd2, m13: 2'd0, m14: 1'b1};

    // The stage schedule (offsets, select decode) only exists for a 32-point FFT.
    localparam int SCHED_N     = 32;
    localparam int SCHED_LOG2N = 5;

    function automatic bit cfg_legal(input int n, input int log2n, input int addr_bit);
        return (n == SCHED_N) && (log2n == SCHED_LOG2N) && (n == 4 * (1 << addr_bit));
    endfunction

endpackage

// File: rtl/rfft_ctrl_if.sv
// rfft_ctrl_if: host/datapath-facing control bundle of rfft_ctrl.
// RFFT_CTRL_STALL_EN adds the stall input to the bundle.
interface rfft_ctrl_if #(
    parameter int ADDR_BIT = 3,
    parameter int LOG2N    = 5
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [ADDR_BIT-1:0]   ld_idx;
    logic                  m0;
    logic                  m11;
    logic [1:0]            m12;
    logic [1:0]            m13;
    logic                  m14;
    logic                  m21;
    logic                  m22;
    logic                  m23;
    logic                  m24;
    logic                  bypass_en;
    logic [LOG2N-2:0]      tw_addr;
    logic [4*ADDR_BIT-1:0] addr_read;
    logic [4*ADDR_BIT-1:0] addr_write;
    logic                  we;

`ifdef RFFT_CTRL_STALL_EN
    logic                  stall;

    modport master (
        output start, stall,
        input  busy, done, ld_idx, m0, m11, m12, m13, m14, m21, m22, m23, m24,
               bypass_en, tw_addr, addr_read, addr_write, we
    );
    modport slave (
        input  start, stall,
        output busy, done, ld_idx, m0, m11, m12, m13, m14, m21, m22, m23, m24,
               bypass_en, tw_addr, addr_read, addr_write, we
    );
`else
    modport master (
        output start,
        input  busy, done, ld_idx, m0, m11, m12, m13, m14, m21, m22, m23, m24,
               bypass_en, tw_addr, addr_read, addr_write, we
    );
    modport slave (
        input  start,
        output busy, done, ld_idx, m0, m11, m12, m13, m14, m21, m22, m23, m24,
               bypass_en, tw_addr, addr_read, addr_write, we
    );
`endif
endinterface

// File: rtl/rfft_wb_delay.sv
// rfft_wb_delay: LAT-deep shift register carrying {write address, valid} from
// the read side to the write-back side. clr is a synchronous clear; hold
// freezes every entry.
module rfft_wb_delay #(
    parameter int W   = 12,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         hold,
    input  logic [W-1:0] in_addr,
    input  logic         in_vld,
    output logic [W-1:0] out_addr,
    output logic         out_vld
);
    typedef struct packed {
        logic [W-1:0] addr;
        logic         vld;
    } ent_t;

    ent_t [LAT-1:0] line_q, line_d;

    // Shift one slot per cycle unless held.
    always_comb begin
        line_d = line_q;
        if (!hold) begin
            line_d[0] = '{addr: in_addr, vld: in_vld};
            for (int i = 1; i < LAT; i++) begin
                line_d[i] = line_q[i-1];
            end
        end
    end

    // Line register, cleared synchronously.
    always_ff @(posedge clk) begin
        if (clr) line_q <= '0;
        else     line_q <= line_d;
    end

    assign out_addr = line_q[LAT-1].addr;
    assign out_vld  = line_q[LAT-1].vld;

endmodule

// File: rtl/rfft_ctrl.sv
// rfft_ctrl: sequencer for the rfft_4pt datapath. A start pulse loads N samples
// into four banks, then runs LOG2N radix-2 stages, each followed by a
// PIPE_LAT-cycle drain, and pulses done.
// RFFT_CTRL_STALL_EN adds a stall input that freezes LOAD/STAGE/DRAIN progress.
module rfft_ctrl
    import rfft_pkg::*;
#(
    parameter int ADDR_BIT = 3,
    parameter int N        = 32,
    parameter int LOG2N    = 5,
    parameter int PIPE_LAT = 2
) (
    input logic        clk,
    input logic        rst,
    rfft_ctrl_if.slave bus
);
    localparam int MEM_HEIGHT = 1 << ADDR_BIT;
    localparam int AW4        = 4 * ADDR_BIT;
    localparam int TW_W       = LOG2N - 1;
    localparam int STG_W      = $clog2(LOG2N);
    localparam int TWF_W      = ADDR_BIT + LOG2N;

    localparam logic [ADDR_BIT-1:0] CNT_LAST = ADDR_BIT'(MEM_HEIGHT - 1);
    localparam logic [ADDR_BIT-1:0] DRN_LAST = ADDR_BIT'(PIPE_LAT - 1);
    localparam logic [STG_W-1:0]    STG_LAST = STG_W'(LOG2N - 1);

    generate
        if (!cfg_legal(N, LOG2N, ADDR_BIT)) begin : g_bad_cfg
            $error("rfft_ctrl: schedule exists only for N=32, LOG2N=5, ADDR_BIT=3");
        end
        // The drain reuses the row counter.
        if (PIPE_LAT < 1 || PIPE_LAT > MEM_HEIGHT) begin : g_bad_lat
            $error("rfft_ctrl: PIPE_LAT must be in 1..MEM_HEIGHT");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [ADDR_BIT-1:0] cnt_q, cnt_d;
    logic [STG_W-1:0]    stg_q, stg_d;

    // Last STAGE-cycle selects, replayed during DRAIN.
    row1_t               r1_hold_q, r1_hold_d;
    logic [3:0]          r2_hold_q, r2_hold_d;
    logic                byp_hold_q, byp_hold_d;
    logic [TW_W-1:0]     tw_hold_q, tw_hold_d;

    logic                stall_w;
    logic                freeze;
    logic                run_st;

    row1_t               r1_now;
    logic [3:0]          r2_now;
    logic                byp_now;
    logic [TW_W-1:0]     tw_now;
    logic [ADDR_BIT-1:0] rd_lo;

    logic [AW4-1:0]      rd_addr;
    logic [AW4-1:0]      wb_addr;
    logic                wb_vld;
    logic                push_vld;

    row1_t               r1_o;
    logic [3:0]          r2_o;
    logic                byp_o;
    logic [TW_W-1:0]     tw_o;
    logic                m0_o;
    logic [ADDR_BIT-1:0] ldi_o;
    logic [AW4-1:0]      awr_o;
    logic                we_o;

`ifdef RFFT_CTRL_STALL_EN
    assign stall_w = bus.stall;
`else
    assign stall_w = 1'b0;
`endif

    assign run_st = (state_q == S_LOAD) || (state_q == S_STAGE) || (state_q == S_DRAIN);
    // Stall only matters while the sequence is actually running.
    assign freeze = stall_w && run_st;

    // Stage decode: mux selects, twiddle index and bank read offset for (stg, cnt).
    always_comb begin
        r1_now = ROW1_A;
        r2_now = 4'b0011;
        case (int'(stg_q))
            0: begin
                r1_now = ROW1_D;
                r2_now = cnt_q[2] ? 4'b1100 : 4'b0011;
            end
            1: begin
                r1_now = cnt_q[2] ? ROW1_B : ROW1_A;
                r2_now = cnt_q[1] ? 4'b1100 : 4'b0011;
            end
            2: begin
                if (cnt_q[2:1] == 2'b00) r1_now = ROW1_A;
                else if (cnt_q[1])       r1_now = ROW1_C;
                else                     r1_now = ROW1_D;
                r2_now = cnt_q[0] ? 4'b1100 : 4'b0011;
            end
            3: begin
                if (cnt_q == '0)   r1_now = ROW1_A;
                else if (cnt_q[0]) r1_now = ROW1_C;
                else               r1_now = ROW1_D;
            end
            default: r1_now = ROW1_A;
        endcase
        byp_now = (stg_q <= STG_W'(2));
        tw_now  = TW_W'(TWF_W'(cnt_q) << stg_q);
        rd_lo   = cnt_q + ADDR_BIT'(OFF_TBL[stg_q]);
    end

    // Sequencer next state: IDLE -> LOAD -> (STAGE -> DRAIN) x LOG2N -> FIN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        if (!freeze) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                        stg_d   = '0;
                    end
                end
                S_LOAD: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_STAGE;
                        cnt_d   = '0;
                        stg_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_BIT'(1);
                    end
                end
                S_STAGE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_BIT'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == DRN_LAST) begin
                        cnt_d = '0;
                        if (stg_q == STG_LAST) begin
                            state_d = S_FIN;
                        end else begin
                            stg_d   = stg_q + STG_W'(1);
                            state_d = S_STAGE;
                        end
                    end else begin
                        cnt_d = cnt_q + ADDR_BIT'(1);
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    stg_d   = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Capture the current selects every STAGE cycle so DRAIN can replay them.
    always_comb begin
        r1_hold_d  = r1_hold_q;
        r2_hold_d  = r2_hold_q;
        byp_hold_d = byp_hold_q;
        tw_hold_d  = tw_hold_q;
        if (state_q == S_STAGE) begin
            r1_hold_d  = r1_now;
            r2_hold_d  = r2_now;
            byp_hold_d = byp_now;
            tw_hold_d  = tw_now;
        end
    end

    // Output decode; everything idles at zero outside the running states.
    always_comb begin
        r1_o    = '0;
        r2_o    = '0;
        byp_o   = 1'b0;
        tw_o    = '0;
        m0_o    = 1'b0;
        ldi_o   = '0;
        rd_addr = '0;
        awr_o   = wb_addr;
        we_o    = wb_vld && !stall_w;
        case (state_q)
            S_LOAD: begin
                ldi_o = cnt_q;
                awr_o = {4{cnt_q}};
                we_o  = !stall_w;
            end
            S_STAGE: begin
                m0_o    = 1'b1;
                r1_o    = r1_now;
                r2_o    = r2_now;
                byp_o   = byp_now;
                tw_o    = tw_now;
                rd_addr = {cnt_q, cnt_q, rd_lo, rd_lo};
            end
            S_DRAIN: begin
                m0_o  = 1'b1;
                r1_o  = r1_hold_q;
                r2_o  = r2_hold_q;
                byp_o = byp_hold_q;
                tw_o  = tw_hold_q;
            end
            default: ;
        endcase
    end

    assign push_vld = (state_q == S_STAGE);

    rfft_wb_delay #(
        .W   (AW4),
        .LAT (PIPE_LAT)
    ) u_wb_delay (
        .clk      (clk),
        .clr      (rst),
        .hold     (freeze),
        .in_addr  (rd_addr),
        .in_vld   (push_vld),
        .out_addr (wb_addr),
        .out_vld  (wb_vld)
    );

    // State, counters and select hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            stg_q      <= '0;
            r1_hold_q  <= '0;
            r2_hold_q  <= '0;
            byp_hold_q <= 1'b0;
            tw_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stg_q      <= stg_d;
            r1_hold_q  <= r1_hold_d;
            r2_hold_q  <= r2_hold_d;
            byp_hold_q <= byp_hold_d;
            tw_hold_q  <= tw_hold_d;
        end
    end

    assign bus.busy       = run_st;
    assign bus.done       = (state_q == S_FIN);
    assign bus.ld_idx     = ldi_o;
    assign bus.m0         = m0_o;
    assign bus.m11        = r1_o.m11;
    assign bus.m12        = r1_o.m12;
    assign bus.m13        = r1_o.m13;
    assign bus.m14        = r1_o.m14;
    assign bus.m21        = r2_o[3];
    assign bus.m22        = r2_o[2];
    assign bus.m23        = r2_o[1];
    assign bus.m24        = r2_o[0];
    assign bus.bypass_en  = byp_o;
    assign bus.tw_addr    = tw_o;
    assign bus.addr_read  = rd_addr;
    assign bus.addr_write = awr_o;
    assign bus.we         = we_o;

endmodule
